ysyx_22040127_decode_stage: RTL

- Registered RISC-V decode stage between IF and EX.
- Accepts one instruction and PC per valid/ready handshake and decodes opcode class, register indices, immediate and control flags.
- Holds the result in an output pipeline register with valid/ready toward EX.
- Adds parametrised XLEN, illegal-opcode detection, rd-zero write suppression, load-use bubble insertion, flush, and a stall counter.

---
 rtl/ysyx_22040127_decode_stage_if.sv | 51 +++++
 rtl/ysyx_22040127_decode_stage.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/ysyx_22040127_decode_stage_if.sv
// ----------------------------------------------------------------------------
// ysyx_22040127_decode_stage_if
// Bundles the IF-side handshake, the EX-side decoded bundle and the stall
// counter of the decode stage.
//   slave  : view taken by the decode stage (drives in_ready and all out_*).
//   master : view taken by the surrounding pipeline or a testbench.
// Signals:
//   in_valid/in_ready/in_inst/in_pc : instruction handshake from IF
//   flush                           : kill held bundle, drop input this cycle
//   out_valid/out_ready             : handshake toward EX
//   out_pc/out_rd/out_rs1/out_rs2/out_type/out_imm and control flags
//   stall_cnt                       : saturating count of load-use bubbles
// ----------------------------------------------------------------------------
interface ysyx_22040127_decode_stage_if #(
  parameter int XLEN  = 64,
  parameter int CNT_W = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_inst;
  logic [XLEN-1:0]  in_pc;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_pc;
  logic [4:0]       out_rd;
  logic [4:0]       out_rs1;
  logic [4:0]       out_rs2;
  logic [2:0]       out_type;
  logic [XLEN-1:0]  out_imm;
  logic             out_reg_wen;
  logic             out_memread;
  logic             out_memwrite;
  logic             out_ebreak;
  logic             out_illegal;
  logic [CNT_W-1:0] stall_cnt;

  modport slave (
    input  in_valid, in_inst, in_pc, flush, out_ready,
    output in_ready, out_valid, out_pc, out_rd, out_rs1, out_rs2, out_type,
           out_imm, out_reg_wen, out_memread, out_memwrite, out_ebreak,
           out_illegal, stall_cnt
  );

  modport master (
    output in_valid, in_inst, in_pc, flush, out_ready,
    input  in_ready, out_valid, out_pc, out_rd, out_rs1, out_rs2, out_type,
           out_imm, out_reg_wen, out_memread, out_memwrite, out_ebreak,
           out_illegal, stall_cnt
  );
endinterface

// File: rtl/ysyx_22040127_decode_stage.sv
// ----------------------------------------------------------------------------
// ysyx_22040127_decode_stage
// Registered RISC-V decode stage between IF and EX. Decodes one instruction
// per handshake into opcode class, register indices, sign-extended immediate
// and control flags, and holds it in an output register toward EX.
// Inserts one bubble when the instruction on the input needs the rd of a
// load currently held in the output register, and counts those bubbles.
// Ports:
//   clk  : clock
//   rst  : synchronous active-high reset
//   bus  : ysyx_22040127_decode_stage_if.slave (handshakes, bundle, counter)
// Type encoding: I=000 U=001 S=010 J=011 R=100 B=101 N=110 X(illegal)=111
// ----------------------------------------------------------------------------
module ysyx_22040127_decode_stage #(
  parameter int XLEN  = 64,
  parameter int CNT_W = 32
) (
  input logic clk,
  input logic rst,
  ysyx_22040127_decode_stage_if.slave bus
);

  typedef enum logic [2:0] {
    T_I = 3'b000,
    T_U = 3'b001,
    T_S = 3'b010,
    T_J = 3'b011,
    T_R = 3'b100,
    T_B = 3'b101,
    T_N = 3'b110,
    T_X = 3'b111
  } inst_type_e;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_IMM32  = 7'b0011011;
  localparam logic [6:0] OP_REG32  = 7'b0111011;

  localparam logic [31:0] EBREAK_WORD = 32'h0010_0073;

  logic [31:0]     inst;
  logic [6:0]      opcode;
  logic [4:0]      rd;
  logic [4:0]      rs1;
  logic [4:0]      rs2;
  inst_type_e      dec_type;
  logic [31:0]     imm32;
  logic [XLEN-1:0] dec_imm;
  logic            uses_rs1;
  logic            uses_rs2;
  logic            dec_reg_wen;
  logic            hazard;

  assign inst   = bus.in_inst;
  assign opcode = inst[6:0];
  assign rd     = inst[11:7];
  assign rs1    = inst[19:15];
  assign rs2    = inst[24:20];

  // NOTE: every signal written in an always_comb block gets a default on the
  // first line so that no path leaves it unassigned and infers a latch.
  always_comb begin
    dec_type = T_X;
    case (opcode)
      OP_LUI, OP_AUIPC:          dec_type = T_U;
      OP_IMM, OP_LOAD, OP_JALR:  dec_type = T_I;
      OP_JAL:                    dec_type = T_J;
      OP_REG:                    dec_type = T_R;
      OP_STORE:                  dec_type = T_S;
      OP_BRANCH:                 dec_type = T_B;
      OP_SYSTEM:                 dec_type = T_N;
      // Word-sized ops only exist on RV64.
      OP_IMM32:                  dec_type = (XLEN == 64) ? T_I : T_X;
      OP_REG32:                  dec_type = (XLEN == 64) ? T_R : T_X;
      default:                   dec_type = T_X;
    endcase
  end

  // Every immediate fits in 32 bits, so build it there and sign-extend once.
  always_comb begin
    imm32 = '0;
    case (dec_type)
      T_I, T_N: imm32 = {{20{inst[31]}}, inst[31:20]};
      T_S:      imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      T_B:      imm32 = {{19{inst[31]}}, inst[31], inst[7], inst[30:25],
                         inst[11:8], 1'b0};
      T_U:      imm32 = {inst[31:12], 12'b0};
      T_J:      imm32 = {{11{inst[31]}}, inst[31], inst[19:12], inst[20],
                         inst[30:21], 1'b0};
      default:  imm32 = '0;
    endcase
  end

  assign dec_imm     = XLEN'($signed(imm32));
  assign uses_rs1    = dec_type inside {T_I, T_S, T_R, T_B};
  assign uses_rs2    = dec_type inside {T_S, T_R, T_B};
  assign dec_reg_wen = (dec_type inside {T_I, T_U, T_J, T_R}) && (rd != 5'd0);

  // Load-use: the held bundle is a load whose rd the incoming instruction
  // reads; the load result is not available to EX in time.
  assign hazard = bus.in_valid && bus.out_valid && bus.out_memread &&
                  (bus.out_rd != 5'd0) &&
                  ((uses_rs1 && (rs1 == bus.out_rd)) ||
                   (uses_rs2 && (rs2 == bus.out_rd)));

  assign bus.in_ready = !bus.flush && !hazard && (!bus.out_valid || bus.out_ready);

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the payload is cleared too, not just out_valid, because EX may
      // observe the fields right after reset and expects zeros there.
      bus.out_valid    <= 1'b0;
      bus.out_pc       <= '0;
      bus.out_rd       <= '0;
      bus.out_rs1      <= '0;
      bus.out_rs2      <= '0;
      bus.out_type     <= '0;
      bus.out_imm      <= '0;
      bus.out_reg_wen  <= 1'b0;
      bus.out_memread  <= 1'b0;
      bus.out_memwrite <= 1'b0;
      bus.out_ebreak   <= 1'b0;
      bus.out_illegal  <= 1'b0;
      bus.stall_cnt    <= '0;
    end else if (bus.flush) begin
      bus.out_valid <= 1'b0;
    end else if (bus.in_valid && bus.in_ready) begin
      bus.out_valid    <= 1'b1;
      bus.out_pc       <= bus.in_pc;
      bus.out_rd       <= rd;
      bus.out_rs1      <= rs1;
      bus.out_rs2      <= rs2;
      bus.out_type     <= dec_type;
      bus.out_imm      <= dec_imm;
      bus.out_reg_wen  <= dec_reg_wen;
      bus.out_memread  <= (opcode == OP_LOAD);
      bus.out_memwrite <= (dec_type == T_S);
      bus.out_ebreak   <= (inst == EBREAK_WORD);
      bus.out_illegal  <= (dec_type == T_X);
    end else if (hazard && bus.out_ready) begin
      // The load moves on to EX and a bubble takes its place.
      bus.out_valid <= 1'b0;
      if (bus.stall_cnt != '1) begin
        bus.stall_cnt <= bus.stall_cnt + 1'b1;
      end
    end else if (bus.out_valid && bus.out_ready && !bus.in_valid) begin
      bus.out_valid <= 1'b0;
    end
  end

endmodule
